// File: rtl/fq_meas_if.sv
// rtl/fq_meas_if.sv - result handshake bundle between the frequency meter and its consumer
interface fq_meas_if #(
    parameter int CNT_LEN = 8
) ();
    logic [CNT_LEN-1:0] meas_out;
    logic               meas_valid;
    logic               meas_ready;
    logic               meas_lost;

    modport master (
        output meas_out,
        output meas_valid,
        output meas_lost,
        input  meas_ready
    );

    modport slave (
        input  meas_out,
        input  meas_valid,
        input  meas_lost,
        output meas_ready
    );
endinterface

// File: rtl/fq_meas.sv
// rtl/fq_meas.sv - half-period meter: counts clk cycles between sig_in edges, with timeout and lock
module fq_meas #(
    parameter int CNT_LEN     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_N      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          sig_in,
    fq_meas_if.master     m,
    output logic          ovf,
    output logic          lock
);
    typedef enum logic [1:0] {IDLE, ARM, MEAS, TMO} state_t;

    localparam logic [CNT_LEN-1:0] CNT_MAX = '1;
    localparam logic [3:0]         LK_MAX  = 4'(LOCK_N - 1);

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic                    p_q, p_d;
    logic [CNT_LEN-1:0]      cnt_q, cnt_d;
    logic [CNT_LEN-1:0]      prev_q, prev_d;
    logic                    have_q, have_d;
    logic [3:0]              lk_q, lk_d;
    logic                    ovf_q, ovf_d;
    logic [CNT_LEN-1:0]      out_q, out_d;
    logic                    valid_q, valid_d;
    logic                    lost_q, lost_d;
    logic                    s;
    logic                    edge_det;
    logic                    capture;

    assign s        = sync_q[SYNC_STAGES-1];
    assign edge_det = s ^ p_q;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], sig_in};
        p_d     = s;
        state_d = state_q;
        cnt_d   = cnt_q;
        prev_d  = prev_q;
        have_d  = have_q;
        lk_d    = lk_q;
        ovf_d   = ovf_q;
        out_d   = out_q;
        valid_d = valid_q;
        lost_d  = 1'b0;
        capture = 1'b0;

        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            lk_d    = '0;
            have_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: state_d = ARM;
                ARM: begin
                    if (edge_det) begin
                        cnt_d   = CNT_LEN'(1);
                        state_d = MEAS;
                    end
                end
                MEAS: begin
                    if (edge_det) begin
                        capture = 1'b1;
                        cnt_d   = CNT_LEN'(1);
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = TMO;
                        ovf_d   = 1'b1;
                        lk_d    = '0;
                        have_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                TMO: begin
                    if (edge_det) begin
                        ovf_d   = 1'b0;
                        cnt_d   = CNT_LEN'(1);
                        state_d = MEAS;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Lock tracks runs of identical results; the first result after a restart has nothing to match.
        if (capture) begin
            have_d = 1'b1;
            prev_d = cnt_q;
            if (have_q && (cnt_q == prev_q)) begin
                lk_d = (lk_q == LK_MAX) ? lk_q : lk_q + 4'd1;
            end else begin
                lk_d = '0;
            end
        end

        if (capture) begin
            out_d   = cnt_q;
            valid_d = 1'b1;
            lost_d  = valid_q & ~m.meas_ready;
        end else if (valid_q && m.meas_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q  <= '0;
            p_q     <= 1'b0;
            cnt_q   <= '0;
            prev_q  <= '0;
            have_q  <= 1'b0;
            lk_q    <= '0;
            ovf_q   <= 1'b0;
            out_q   <= '0;
            valid_q <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            have_q  <= have_d;
            lk_q    <= lk_d;
            ovf_q   <= ovf_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            lost_q  <= lost_d;
        end
    end

    assign m.meas_out   = out_q;
    assign m.meas_valid = valid_q;
    assign m.meas_lost  = lost_q;
    assign ovf          = ovf_q;
    assign lock         = (lk_q == LK_MAX);
endmodule
